flag_search: RTL and testbench

- Hardware brute-force sequencer that sits directly upstream of the combinational flag checker (byte index + byte guess in, guess_valid out).
- Sweeps every candidate byte for every index and captures the first guess the checker accepts.
- Emits one recovered byte per index on a valid/ready stream to the downstream UART/readout logic.
- Replaces the simulation-only sweep with synthesizable, cycle-exact sequencing.

---
 rtl/flag_search_pkg.sv | 22 ++
 rtl/flag_search_if.sv | 29 ++
 rtl/flag_search.sv | 165 ++++++++++++++++
 tb/tb_flag_search.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_search_pkg.sv
// Shared sizing defaults, sweep-state encoding and helpers for the flag search sequencer.
package flag_search_pkg;

   localparam int NUM_BYTES_DEF = 32;
   localparam int IDX_W_DEF     = 5;
   localparam int BYTE_W_DEF    = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_EMIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Highest candidate value for a guess of the given width.
   function automatic int guess_max(input int width);
      return (2 ** width) - 1;
   endfunction

   localparam int GUESS_MAX = guess_max(BYTE_W_DEF);

endpackage

// File: rtl/flag_search_if.sv
// Checker-facing guess bus plus the recovered-byte valid/ready stream.
interface flag_search_if
   import flag_search_pkg::*;
#(
   parameter int IDX_W  = IDX_W_DEF,
   parameter int BYTE_W = BYTE_W_DEF
);

   logic [IDX_W-1:0]  byte_num;
   logic [BYTE_W-1:0] byte_guess;
   logic              guess_valid;

   logic              out_valid;
   logic              out_ready;
   logic [IDX_W-1:0]  out_idx;
   logic [BYTE_W-1:0] out_byte;
   logic              out_miss;

   modport master (
      output byte_num, byte_guess, out_valid, out_idx, out_byte, out_miss,
      input  guess_valid, out_ready
   );

   modport slave (
      input  byte_num, byte_guess, out_valid, out_idx, out_byte, out_miss,
      output guess_valid, out_ready
   );

endinterface

// File: rtl/flag_search.sv
// Brute-force sequencer: sweeps every guess per index against an external checker and
// streams one recovered byte (or a miss marker) per index.
module flag_search
   import flag_search_pkg::*;
#(
   parameter int NUM_BYTES = NUM_BYTES_DEF,
   parameter int IDX_W     = IDX_W_DEF,
   parameter int BYTE_W    = BYTE_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   flag_search_if.master  bus,
   output logic           busy,
   output logic           done,
   output logic [IDX_W:0] miss_count
);

   localparam logic [BYTE_W-1:0] LAST_GUESS = BYTE_W'(guess_max(BYTE_W));
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_BYTES - 1);
   localparam logic [BYTE_W-1:0] GUESS_ONE  = {{(BYTE_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0]  IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W:0]    MISS_ONE   = {{IDX_W{1'b0}}, 1'b1};

   state_t            state_r;
   state_t            state_s;
   logic              busy_r, done_r, out_valid_r;
   logic              busy_s, done_s, out_valid_s;
   logic [IDX_W-1:0]  byte_num_r;
   logic [BYTE_W-1:0] byte_guess_r;
   logic [IDX_W-1:0]  out_idx_r;
   logic [BYTE_W-1:0] out_byte_r;
   logic              out_miss_r;
   logic [IDX_W:0]    miss_count_r;

   // State register together with the registered status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         out_valid_r <= out_valid_s;
      end
   end

   // Next-state selection
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_s = ST_SCAN;
            end else begin
               state_s = state_r;
            end
         end
         ST_SCAN: begin
            // The checker verdict is tested before the exhaustion test, so a hit on the top guess is a hit.
            if (bus.guess_valid || (byte_guess_r == LAST_GUESS)) begin
               state_s = ST_EMIT;
            end else begin
               state_s = ST_SCAN;
            end
         end
         ST_EMIT: begin
            if (bus.out_ready) begin
               if (byte_num_r == LAST_IDX) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_SCAN;
               end
            end else begin
               state_s = ST_EMIT;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Status flags follow the state being entered so they register alongside it
   always_comb begin
      busy_s      = 1'b0;
      done_s      = 1'b0;
      out_valid_s = 1'b0;
      case (state_s)
         ST_SCAN: begin
            busy_s = 1'b1;
         end
         ST_EMIT: begin
            busy_s      = 1'b1;
            out_valid_s = 1'b1;
         end
         ST_DONE: begin
            done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // Sweep counters, captured beat and miss tally
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_num_r   <= {IDX_W{1'b0}};
         byte_guess_r <= {BYTE_W{1'b0}};
         out_idx_r    <= {IDX_W{1'b0}};
         out_byte_r   <= {BYTE_W{1'b0}};
         out_miss_r   <= 1'b0;
         miss_count_r <= {(IDX_W+1){1'b0}};
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  byte_num_r   <= {IDX_W{1'b0}};
                  byte_guess_r <= {BYTE_W{1'b0}};
                  miss_count_r <= {(IDX_W+1){1'b0}};
               end
            end
            ST_SCAN: begin
               if (bus.guess_valid) begin
                  out_byte_r <= byte_guess_r;
                  out_idx_r  <= byte_num_r;
                  out_miss_r <= 1'b0;
               end else if (byte_guess_r == LAST_GUESS) begin
                  out_byte_r   <= {BYTE_W{1'b0}};
                  out_idx_r    <= byte_num_r;
                  out_miss_r   <= 1'b1;
                  miss_count_r <= miss_count_r + MISS_ONE;
               end else begin
                  byte_guess_r <= byte_guess_r + GUESS_ONE;
               end
            end
            ST_EMIT: begin
               // Counters stay frozen under backpressure; they only move on an accepted beat.
               if (bus.out_ready && (byte_num_r != LAST_IDX)) begin
                  byte_num_r   <= byte_num_r + IDX_ONE;
                  byte_guess_r <= {BYTE_W{1'b0}};
               end
            end
            default: begin
               byte_num_r <= byte_num_r;
            end
         endcase
      end
   end

   assign bus.byte_num   = byte_num_r;
   assign bus.byte_guess = byte_guess_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_idx    = out_idx_r;
   assign bus.out_byte   = out_byte_r;
   assign bus.out_miss   = out_miss_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign miss_count     = miss_count_r;

endmodule

// File: tb/tb_flag_search.sv
// Self-checking bench for flag_search: stub checker, scenario table and a lowest-hit reference model.
module tb_flag_search;
   import flag_search_pkg::*;

   localparam int NB = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       busy;
   logic       done;
   logic [5:0] miss_count;

   int n_checks = 0;
   int n_fail   = 0;

   flag_search_if #(.IDX_W(5), .BYTE_W(8)) bus ();

   flag_search dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   // Stub checker: accepts the flag byte unless masked, plus one optional extra guess.
   logic [7:0] flag_mem  [NB];
   logic       miss_mask [NB];
   int         alt_idx = -1;
   int         alt_val = 0;

   function automatic logic accept(input int idx, input int g);
      if (idx >= NB) return 1'b0;
      return (!miss_mask[idx] && (g == int'(flag_mem[idx]))) || ((idx == alt_idx) && (g == alt_val));
   endfunction

   assign bus.guess_valid = accept(int'(bus.byte_num), int'(bus.byte_guess));

   typedef struct {
      int idx;
      int byte_v;
      bit miss;
      int scan;
   } beat_t;

   typedef struct {
      bit rand_flag;
      int miss_a;
      int miss_b;
      int b0;
      int alt_i;
      int alt_v;
      int ready_mode;
      bit poke;
      int exp_mc;
      int exp_b0;
   } vec_t;

   beat_t exp_q[$];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: the lowest accepted guess wins; none accepted means a 256-cycle miss.
   function automatic int first_hit(input int idx);
      for (int g = 0; g <= GUESS_MAX; g++) begin
         if (accept(idx, g)) return g;
      end
      return -1;
   endfunction

   task automatic configure(input vec_t v);
      string flag_str;
      flag_str = "DUCTF{brut3_f0rc3_in_hw_r0ckz!!}";
      for (int i = 0; i < NB; i++) begin
         if (v.rand_flag) flag_mem[i] = 8'($urandom_range(0, 255));
         else if (i < flag_str.len()) flag_mem[i] = flag_str[i];
         else flag_mem[i] = 8'h21;
         miss_mask[i] = (i == v.miss_a) || (i == v.miss_b);
      end
      if (v.b0 >= 0) flag_mem[0] = 8'(v.b0);
      alt_idx = v.alt_i;
      alt_val = v.alt_v;
   endtask

   // Starts a sweep from the current negedge and follows it until done, checking every beat.
   task automatic run_sweep(input vec_t v);
      beat_t      e;
      int         cyc, beats, mc, guard, stall_cnt, first_b;
      bit         stalled, seen_valid;
      logic [4:0] h_idx, h_num;
      logic [7:0] h_byte, h_guess;
      logic       h_miss;

      exp_q.delete();
      mc = 0;
      for (int i = 0; i < NB; i++) begin
         int g;
         g        = first_hit(i);
         e.idx    = i;
         e.byte_v = (g < 0) ? 0 : g;
         e.miss   = (g < 0);
         e.scan   = (g < 0) ? GUESS_MAX + 1 : g + 1;
         if (g < 0) mc++;
         exp_q.push_back(e);
      end

      start = 1'b1;
      bus.out_ready = 1'b1;
      cyc = 0; beats = 0; guard = 0; stall_cnt = 0; first_b = -1;
      stalled = 1'b0; seen_valid = 1'b0;
      h_idx = 5'd0; h_num = 5'd0; h_byte = 8'd0; h_guess = 8'd0; h_miss = 1'b0;

      while (guard < 20000) begin
         @(negedge clk);
         guard++;
         cyc++;
         start = 1'b0;
         if (done) break;

         if (v.ready_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
         else if (v.ready_mode == 2) bus.out_ready = !((beats == 4) && (stall_cnt < 10));
         else bus.out_ready = 1'b1;

         if ((beats == 0) && (cyc == 1)) begin
            check("start_busy", busy, 1);
            check("start_done_clr", done, 0);
            check("start_miss_clr", miss_count, 0);
            check("start_byte_num", bus.byte_num, 0);
         end

         if (busy && !bus.out_valid && (exp_q.size() > 0)) begin
            check("scan_byte_num", bus.byte_num, exp_q[0].idx);
            check("scan_byte_guess", bus.byte_guess, cyc - 1);
         end

         if (bus.out_valid && (exp_q.size() > 0)) begin
            if (!seen_valid) begin
               seen_valid = 1'b1;
               check("beat_latency", cyc, exp_q[0].scan + 1);
            end
            if (stalled) begin
               check("stall_out_idx", bus.out_idx, h_idx);
               check("stall_out_byte", bus.out_byte, h_byte);
               check("stall_out_miss", bus.out_miss, h_miss);
               check("stall_byte_num", bus.byte_num, h_num);
               check("stall_byte_guess", bus.byte_guess, h_guess);
            end
            if (bus.out_ready) begin
               e = exp_q.pop_front();
               check("beat_idx", bus.out_idx, e.idx);
               check("beat_byte", bus.out_byte, e.byte_v);
               check("beat_miss", bus.out_miss, e.miss);
               if (beats == 0) first_b = int'(bus.out_byte);
               beats++;
               cyc = 0;
               seen_valid = 1'b0;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               stall_cnt++;
               h_idx = bus.out_idx; h_byte = bus.out_byte; h_miss = bus.out_miss;
               h_num = bus.byte_num; h_guess = bus.byte_guess;
            end
         end

         if (v.poke && (beats == 2) && (cyc == 5)) start = 1'b1;
      end

      check("sweep_done_in_budget", done, 1);
      check("beat_count", beats, NB);
      check("done_busy_low", busy, 0);
      check("done_valid_low", bus.out_valid, 0);
      check("done_last_idx", bus.out_idx, NB - 1);
      check("done_miss_count_model", miss_count, mc);
      if (v.exp_mc >= 0) check("done_miss_count_table", miss_count, v.exp_mc);
      if (v.exp_b0 >= 0) check("first_beat_byte", first_b, v.exp_b0);
   endtask

   task automatic reset_mid_sweep();
      int guard;
      guard = 0;
      start = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!((bus.byte_num == 5'd7) && busy && !bus.out_valid) && (guard < 5000)) begin
         @(negedge clk);
         guard++;
      end
      check("rst_reach_idx7", longint'(guard < 5000), 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_byte_num", bus.byte_num, 0);
      check("rst_byte_guess", bus.byte_guess, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_idx", bus.out_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_miss_count", miss_count, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("post_rst_idle_busy", busy, 0);
      check("post_rst_idle_valid", bus.out_valid, 0);
      check("post_rst_idle_num", bus.byte_num, 0);
   endtask

   initial begin
      vec_t vecs[6];
      vecs[0] = '{1'b0, -1, -1,    -1, -1,    0, 0, 1'b1, 0, 'h44};
      vecs[1] = '{1'b0,  3, -1,    -1, -1,    0, 0, 1'b0, 1, 'h44};
      vecs[2] = '{1'b0, -1, -1, 'hFF, -1,    0, 0, 1'b0, 0, 'hFF};
      vecs[3] = '{1'b0, -1, -1, 'h20,  0, 'h10, 2, 1'b0, 0, 'h10};
      vecs[4] = '{1'b1,  9, 30,    -1, -1,    0, 1, 1'b0, 2,   -1};
      vecs[5] = '{1'b1,  0, 31,    -1, -1,    0, 1, 1'b0, 2,    0};

      rst = 1'b1;
      start = 1'b0;
      bus.out_ready = 1'b0;
      configure(vecs[0]);
      repeat (3) @(negedge clk);
      check("reset_byte_num", bus.byte_num, 0);
      check("reset_byte_guess", bus.byte_guess, 0);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_out_byte", bus.out_byte, 0);
      check("reset_out_miss", bus.out_miss, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_miss_count", miss_count, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 6; k++) begin
         configure(vecs[k]);
         run_sweep(vecs[k]);
      end

      reset_mid_sweep();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
